video_scan: RTL and testbench

- Display-side reader for the 8 KB dual-port video memory: generates scan timing, issues read addresses on the memory's video port, and serialises bitmap and attribute bytes into coloured pixels.
- Runs entirely in the pixel clock domain.
- The CPU writes the same memory through the other port; this block never writes.
- Implements the ZX Spectrum 256x192 screen layout with border, flash, hsync, vsync and frame interrupt.

---
 rtl/video_scan.sv | 168 ++++++++++++++++
 tb/tb_video_scan.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scan.sv
// Display-side reader for the 8 KB video memory: scan timing, bitmap/attribute
// fetch on the video port, and serialisation into coloured pixels.
module video_scan #(
  parameter int HTOTAL       = 448,
  parameter int VTOTAL       = 312,
  parameter int FLASH_FRAMES = 16,
  parameter int VDISP        = 192,
  parameter int VBLANK_START = 248,
  parameter int VBLANK_END   = 255,
  parameter int VSYNC_START  = 248,
  parameter int VSYNC_END    = 251
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  border,
  output logic [12:0] a,
  input  logic [7:0]  d,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i,
  output logic        blank,
  output logic        hsync,
  output logic        vsync,
  output logic        int_n
);

  localparam logic [8:0] H_LAST   = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(VTOTAL - 1);
  localparam logic [8:0] V_DISP   = 9'(VDISP);
  localparam logic [8:0] VBL_LO   = 9'(VBLANK_START);
  localparam logic [8:0] VBL_HI   = 9'(VBLANK_END);
  localparam logic [8:0] VS_LO    = 9'(VSYNC_START);
  localparam logic [8:0] VS_HI    = 9'(VSYNC_END);
  localparam logic [8:0] FETCH_HI = 9'd255;
  localparam logic [8:0] HDISP_LO = 9'd8;
  localparam logic [8:0] HDISP_HI = 9'd263;
  localparam logic [8:0] HBL_LO   = 9'd320;
  localparam logic [8:0] HBL_HI   = 9'd415;
  localparam logic [8:0] HS_LO    = 9'd344;
  localparam logic [8:0] HS_HI    = 9'd375;
  localparam logic [8:0] INT_HI   = 9'd63;
  localparam int         FLASH_BIT = $clog2(FLASH_FRAMES);
  localparam int         FW        = FLASH_BIT + 1;

  logic [8:0]    hcount_q, hcount_d;
  logic [8:0]    vcount_q, vcount_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [12:0]   a_q, a_d;
  logic [7:0]    bitmap_q, bitmap_d;
  logic [7:0]    attr_hold_q, attr_hold_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    attr_q, attr_d;
  logic [2:0]    colour_q, colour_d;
  logic          bright_q, bright_d;
  logic          blank_q, blank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          int_n_q, int_n_d;

  logic          fetch_now, fetch_next, in_display, pix;
  logic [7:0]    y_n;
  logic [4:0]    c_n;

  // Outputs are computed from the next counter values so that each
  // registered output lines up with the hcount/vcount it belongs to.
  always_comb begin
    hcount_d    = (hcount_q == H_LAST) ? 9'd0 : hcount_q + 9'd1;
    vcount_d    = vcount_q;
    flash_cnt_d = flash_cnt_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? 9'd0 : vcount_q + 9'd1;
      if (vcount_q == V_LAST) flash_cnt_d = flash_cnt_q + FW'(1);
    end

    fetch_now  = (vcount_q < V_DISP) && (hcount_q <= FETCH_HI);
    fetch_next = (vcount_d < V_DISP) && (hcount_d <= FETCH_HI);
    y_n        = vcount_d[7:0];
    c_n        = hcount_d[7:3];

    a_d = a_q;
    if (fetch_next && hcount_d[2:0] == 3'd2)
      a_d = {y_n[7:6], y_n[2:0], y_n[5:3], c_n};
    else if (fetch_next && hcount_d[2:0] == 3'd4)
      a_d = {3'b110, y_n[7:3], c_n};

    // Memory data arrives the cycle after the address is held on `a`.
    bitmap_d    = bitmap_q;
    attr_hold_d = attr_hold_q;
    shift_d     = {shift_q[6:0], 1'b0};
    attr_d      = attr_q;
    if (fetch_now) begin
      case (hcount_q[2:0])
        3'd3: bitmap_d = d;
        3'd5: attr_hold_d = d;
        3'd7: begin
          shift_d = bitmap_q;
          attr_d  = attr_hold_q;
        end
        default: ;
      endcase
    end

    pix        = shift_d[7] ^ (attr_d[7] & flash_cnt_d[FLASH_BIT]);
    in_display = (vcount_d < V_DISP) && (hcount_d >= HDISP_LO) && (hcount_d <= HDISP_HI);
    blank_d    = ((hcount_d >= HBL_LO) && (hcount_d <= HBL_HI)) ||
                 ((vcount_d >= VBL_LO) && (vcount_d <= VBL_HI));
    hsync_d    = !((hcount_d >= HS_LO) && (hcount_d <= HS_HI));
    vsync_d    = !((vcount_d >= VS_LO) && (vcount_d <= VS_HI));
    int_n_d    = !((vcount_d == VS_LO) && (hcount_d <= INT_HI));

    colour_d = 3'd0;
    bright_d = 1'b0;
    if (!blank_d) begin
      if (in_display) begin
        colour_d = pix ? attr_d[2:0] : attr_d[5:3];
        bright_d = attr_d[6];
      end else begin
        colour_d = border;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      flash_cnt_q <= '0;
      a_q         <= '0;
      bitmap_q    <= '0;
      attr_hold_q <= '0;
      shift_q     <= '0;
      attr_q      <= '0;
      colour_q    <= '0;
      bright_q    <= 1'b0;
      blank_q     <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      int_n_q     <= 1'b1;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      flash_cnt_q <= flash_cnt_d;
      a_q         <= a_d;
      bitmap_q    <= bitmap_d;
      attr_hold_q <= attr_hold_d;
      shift_q     <= shift_d;
      attr_q      <= attr_d;
      colour_q    <= colour_d;
      bright_q    <= bright_d;
      blank_q     <= blank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      int_n_q     <= int_n_d;
    end
  end

  assign a     = a_q;
  assign g     = colour_q[2];
  assign r     = colour_q[1];
  assign b     = colour_q[0];
  assign i     = bright_q;
  assign blank = blank_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign int_n = int_n_q;

endmodule

// File: tb/tb_video_scan.sv
// Bench for video_scan: table of fixed points plus a per-cycle reference model
// over random memory and border, with a shortened frame to keep runs short.
module tb_video_scan;

  localparam int HT  = 448;
  localparam int VT  = 74;
  localparam int FF  = 1;
  localparam int VD  = 66;
  localparam int VBS = 68;
  localparam int VBE = 73;
  localparam int VSS = 68;
  localparam int VSE = 71;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  border = 3'd0;
  logic [12:0] a;
  logic [7:0]  d = 8'd0;
  logic        r, g, b, i, blank, hsync, vsync, int_n;

  logic [7:0]  mem [0:8191];

  int nvec = 0;
  int nerr = 0;
  int h = 0, v = 0, frame = 0;
  logic [2:0] bord_cur = 3'd0;
  int vs_lines = 0, int_clks = 0;

  typedef struct {
    int          f;
    int          hh;
    int          vv;
    bit          co;
    logic [7:0]  o;
    bit          ca;
    logic [12:0] ea;
  } vec_t;
  vec_t tbl[$];

  video_scan #(
    .HTOTAL(HT), .VTOTAL(VT), .FLASH_FRAMES(FF), .VDISP(VD),
    .VBLANK_START(VBS), .VBLANK_END(VBE), .VSYNC_START(VSS), .VSYNC_END(VSE)
  ) dut (
    .clock(clock), .reset(reset), .border(border), .a(a), .d(d),
    .r(r), .g(g), .b(b), .i(i), .blank(blank),
    .hsync(hsync), .vsync(vsync), .int_n(int_n)
  );

  always #5 clock = ~clock;
  always @(posedge clock) d <= mem[a];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [12:0] bm_addr(int col, int y);
    return 13'((y / 64) * 2048 + (y % 8) * 256 + ((y / 8) % 8) * 32 + col);
  endfunction

  function automatic logic [12:0] attr_addr(int col, int y);
    return 13'(6144 + (y / 8) * 32 + col);
  endfunction

  // Expected {r,g,b,i,blank,hsync,vsync,int_n} while the scan sits at (hh,vv).
  function automatic logic [7:0] exp_out(int hh, int vv, int ff, logic [2:0] bd);
    int col, ii, x, pix;
    logic [7:0] bm, at;
    logic bl, hs, vs, irq;
    bl  = (hh >= 320 && hh <= 415) || (vv >= VBS && vv <= VBE);
    hs  = !(hh >= 344 && hh <= 375);
    vs  = !(vv >= VSS && vv <= VSE);
    irq = !(vv == VSS && hh < 64);
    col = int'(bd);
    ii  = 0;
    if (bl) begin
      col = 0;
    end else if (vv < VD && hh >= 8 && hh <= 263) begin
      x   = hh - 8;
      bm  = mem[bm_addr(x / 8, vv)];
      at  = mem[attr_addr(x / 8, vv)];
      pix = bm[7 - x % 8] ? 1 : 0;
      if (at[7] && ((ff / FF) % 2 == 1)) pix = 1 - pix;
      col = pix ? int'(at[2:0]) : int'(at[5:3]);
      ii  = at[6] ? 1 : 0;
    end
    return {col[1], col[2], col[0], ii[0], bl, hs, vs, irq};
  endfunction

  function automatic bit a_due(int hh, int vv);
    return (vv < VD) && (hh <= 255) && (hh % 8 >= 2);
  endfunction

  function automatic logic [12:0] exp_a(int hh, int vv);
    return (hh % 8 < 4) ? bm_addr(hh / 8, vv) : attr_addr(hh / 8, vv);
  endfunction

  task automatic fill_mem();
    for (int k = 0; k < 8192; k++) mem[k] = 8'($urandom);
    mem[13'h0000] = 8'hA5;
    mem[13'h0001] = 8'hFF;
    mem[13'h001F] = 8'h01;
    mem[13'h1800] = 8'h47;
    mem[13'h1801] = 8'h87;
    mem[13'h181F] = 8'h3A;
  endtask

  task automatic add(input int f, input int hh, input int vv, input bit co,
                     input logic [7:0] o, input bit ca, input logic [12:0] ea);
    vec_t e;
    e.f = f; e.hh = hh; e.vv = vv; e.co = co; e.o = o; e.ca = ca; e.ea = ea;
    tbl.push_back(e);
  endtask

  task automatic step();
    logic [7:0] got, want;
    @(posedge clock);
    bord_cur = border;
    if (h == HT - 1) begin
      h = 0;
      if (v == VT - 1) begin v = 0; frame++; end
      else v++;
    end else begin
      h++;
    end
    @(negedge clock);
    got  = {r, g, b, i, blank, hsync, vsync, int_n};
    want = exp_out(h, v, frame, bord_cur);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL model f%0d v%0d h%0d: outputs %b, expected %b", frame, v, h, got, want);
    end
    if (a_due(h, v)) begin
      nvec++;
      if (a !== exp_a(h, v)) begin
        nerr++;
        $display("FAIL addr f%0d v%0d h%0d: a=%h, expected %h", frame, v, h, a, exp_a(h, v));
      end
    end
    if (!vsync && h == 0) vs_lines++;
    if (!int_n) int_clks++;
    border = (v == 10) ? 3'b010 : 3'($urandom_range(0, 7));
    if (h == 0 && v == VD) fill_mem();
  endtask

  task automatic check_reset_values(input string tag);
    nvec++;
    if ({r, g, b, i, blank, hsync, vsync, int_n} !== 8'b0000_0111 || a !== 13'd0) begin
      nerr++;
      $display("FAIL %s: outputs %b a=%h, expected 00000111 a=0000", tag,
               {r, g, b, i, blank, hsync, vsync, int_n}, a);
    end
  endtask

  initial begin
    int n;
    // Fixed points: {frame, hcount, vcount, check outputs, outputs, check a, a}
    add(0,   8, 0, 1, 8'hF7, 0, 13'h0);
    add(0,   9, 0, 1, 8'h17, 0, 13'h0);
    add(0,  10, 0, 1, 8'hF7, 0, 13'h0);
    add(0,  11, 0, 1, 8'h17, 0, 13'h0);
    add(0,  12, 0, 1, 8'h17, 0, 13'h0);
    add(0,  13, 0, 1, 8'hF7, 0, 13'h0);
    add(0,  14, 0, 1, 8'h17, 0, 13'h0);
    add(0,  15, 0, 1, 8'hF7, 0, 13'h0);
    add(0,  16, 0, 1, 8'hE7, 0, 13'h0);
    add(0,  23, 0, 1, 8'hE7, 0, 13'h0);
    add(0, 262, 0, 1, 8'hE7, 0, 13'h0);
    add(0, 263, 0, 1, 8'h87, 0, 13'h0);
    add(0, 320, 1, 1, 8'h0F, 0, 13'h0);
    add(0, 343, 1, 1, 8'h0F, 0, 13'h0);
    add(0, 344, 1, 1, 8'h0B, 0, 13'h0);
    add(0, 375, 1, 1, 8'h0B, 0, 13'h0);
    add(0, 376, 1, 1, 8'h0F, 0, 13'h0);
    add(0, 300, 10, 1, 8'h87, 0, 13'h0);
    add(0, 350, 10, 1, 8'h0B, 0, 13'h0);
    add(0,  26, 65, 0, 8'h00, 1, 13'h0903);
    add(0,  28, 65, 0, 8'h00, 1, 13'h1903);
    add(0, 330, 67, 1, 8'h0F, 0, 13'h0);
    add(0,   0, 68, 1, 8'h0C, 0, 13'h0);
    add(0,  63, 68, 1, 8'h0C, 0, 13'h0);
    add(0,  64, 68, 1, 8'h0D, 0, 13'h0);
    add(0,   0, 71, 1, 8'h0D, 0, 13'h0);
    add(0,   0, 73, 1, 8'h0F, 0, 13'h0);
    add(1,   8, 0, 1, 8'hF7, 0, 13'h0);
    add(1,  16, 0, 1, 8'h07, 0, 13'h0);
    add(1,  23, 0, 1, 8'h07, 0, 13'h0);

    fill_mem();
    repeat (5) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset_hold");
    reset = 1'b1;

    foreach (tbl[k]) begin
      int guard;
      guard = 0;
      while (!(frame == tbl[k].f && h == tbl[k].hh && v == tbl[k].vv) && guard < 100000) begin
        step();
        guard++;
      end
      nvec++;
      if (guard >= 100000) begin
        nerr++;
        $display("FAIL table[%0d]: position f%0d v%0d h%0d never reached", k, tbl[k].f, tbl[k].vv, tbl[k].hh);
      end else begin
        if (tbl[k].co && {r, g, b, i, blank, hsync, vsync, int_n} !== tbl[k].o) begin
          nerr++;
          $display("FAIL table[%0d] f%0d v%0d h%0d: outputs %b, expected %b", k, frame, v, h,
                   {r, g, b, i, blank, hsync, vsync, int_n}, tbl[k].o);
        end
        if (tbl[k].ca && a !== tbl[k].ea) begin
          nerr++;
          $display("FAIL table[%0d] addr v%0d h%0d: a=%h, expected %h", k, v, h, a, tbl[k].ea);
        end
      end
    end

    nvec++;
    if (vs_lines != 4) begin
      nerr++;
      $display("FAIL vsync_lines: %0d lines low, expected 4", vs_lines);
    end
    nvec++;
    if (int_clks != 64) begin
      nerr++;
      $display("FAIL int_width: int_n low %0d clocks, expected 64", int_clks);
    end

    n = 0;
    while (!(h == 130 && v == 50) && n < 100000) begin
      step();
      n++;
    end
    reset = 1'b0;
    #1;
    check_reset_values("reset_async");
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_values("reset_held_midline");
    reset = 1'b1;

    n = 0;
    while (hsync !== 1'b0 && n < 2000) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    nvec++;
    if (n != 344) begin
      nerr++;
      $display("FAIL hsync_after_reset: first hsync after %0d clocks, expected 344", n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
